// File: rtl/mult_controller.sv
// mult_controller
//   Moore FSM sequencing a repeated-addition unsigned multiplier datapath:
//   load operands, preload R1 with A, add A (B-1) times while the datapath
//   counter decrements, then store the product in F_REG. An iteration guard
//   aborts with ERROR if the datapath status never ends the add loop.
//
// Ports
//   SYS_CLOCK    in   system clock, rising edge
//   SYS_RESET_N  in   synchronous active-low reset
//   START        in   multiply request, sampled only in IDLE
//   B_GT_1       in   datapath status: count>2 or B_REG>1
//   COUNT_GT_2   in   datapath status: count>2
//   ALU_CONT     out  00 pass A_REG, 01 R1+A_REG, 10 zero
//   LOAD_A_REG   out  load A_REG
//   LOAD_B_REG   out  load B_REG
//   LOAD_R1_REG  out  load R1 from ALU_OUT
//   LOAD_F_REG   out  load F_REG
//   LOAD_COUNT   out  counter <= B_REG
//   DEC_COUNT    out  counter <= counter-1
//   BUSY         out  high in every state except IDLE
//   DONE         out  one-cycle completion pulse
//   ERROR        out  sticky abort flag
module mult_controller #(
  parameter int unsigned MULTIPLIER_WIDTH = 3,
  parameter int unsigned GUARD_WIDTH      = MULTIPLIER_WIDTH
) (
  input  logic       SYS_CLOCK,
  input  logic       SYS_RESET_N,
  input  logic       START,
  input  logic       B_GT_1,
  input  logic       COUNT_GT_2,
  output logic [1:0] ALU_CONT,
  output logic       LOAD_A_REG,
  output logic       LOAD_B_REG,
  output logic       LOAD_R1_REG,
  output logic       LOAD_F_REG,
  output logic       LOAD_COUNT,
  output logic       DEC_COUNT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam int unsigned GUARD_MAX = (2 ** MULTIPLIER_WIDTH) - 2;
  localparam logic [GUARD_WIDTH-1:0] GUARD_LIMIT = GUARD_WIDTH'(GUARD_MAX);

  localparam logic [1:0] ALU_PASS_A = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_ZERO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRELOAD,
    S_CHECK,
    S_ADD,
    S_STORE,
    S_FIN,
    S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [GUARD_WIDTH-1:0] guard_q, guard_d;
  logic                   error_q, error_d;

  logic [1:0] alu_cont_q, alu_cont_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       load_r1_q, load_r1_d;
  logic       load_f_q, load_f_d;
  logic       load_count_q, load_count_d;
  logic       dec_count_q, dec_count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          error_d = 1'b0;
          guard_d = '0;
        end
      end
      S_LOAD:    state_d = S_PRELOAD;
      S_PRELOAD: state_d = S_CHECK;
      S_CHECK:   state_d = B_GT_1 ? S_ADD : S_STORE;
      S_ADD: begin
        if (guard_q == GUARD_LIMIT) begin
          state_d = S_ERR;
          // Raised on entry so ERROR is already high in the ERR cycle.
          error_d = 1'b1;
        end else begin
          guard_d = guard_q + GUARD_WIDTH'(1);
          state_d = COUNT_GT_2 ? S_ADD : S_STORE;
        end
      end
      S_STORE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: decode the state being entered (and the guard it
  // will hold) so the flop values equal a pure decode of the current state.
  always_comb begin
    alu_cont_d   = ALU_ZERO;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    load_r1_d    = 1'b0;
    load_f_d     = 1'b0;
    load_count_d = 1'b0;
    dec_count_d  = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d != S_IDLE);

    case (state_d)
      S_LOAD: begin
        load_a_d = 1'b1;
        load_b_d = 1'b1;
      end
      S_PRELOAD: begin
        alu_cont_d   = ALU_PASS_A;
        load_r1_d    = 1'b1;
        load_count_d = 1'b1;
      end
      S_ADD: begin
        if (guard_d != GUARD_LIMIT) begin
          alu_cont_d  = ALU_ADD;
          load_r1_d   = 1'b1;
          dec_count_d = 1'b1;
        end
      end
      S_STORE: load_f_d = 1'b1;
      S_FIN:   done_d   = 1'b1;
      S_ERR:   done_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (!SYS_RESET_N) begin
      state_q      <= S_IDLE;
      guard_q      <= '0;
      error_q      <= 1'b0;
      alu_cont_q   <= ALU_ZERO;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      load_r1_q    <= 1'b0;
      load_f_q     <= 1'b0;
      load_count_q <= 1'b0;
      dec_count_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      error_q      <= error_d;
      alu_cont_q   <= alu_cont_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      load_r1_q    <= load_r1_d;
      load_f_q     <= load_f_d;
      load_count_q <= load_count_d;
      dec_count_q  <= dec_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ALU_CONT    = alu_cont_q;
  assign LOAD_A_REG  = load_a_q;
  assign LOAD_B_REG  = load_b_q;
  assign LOAD_R1_REG = load_r1_q;
  assign LOAD_F_REG  = load_f_q;
  assign LOAD_COUNT  = load_count_q;
  assign DEC_COUNT   = dec_count_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_mult_controller.sv
// Testbench for mult_controller: closed loop with a small multiplier datapath,
// table-driven operations, randomized operations against an arithmetic model,
// plus hand-written reset, ignored-START and guard-abort sequences.
module tb_mult_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, tie_status;
  logic       b_gt_1, count_gt_2;
  logic [1:0] alu_cont;
  logic       la, lb, lr1, lf, lc, dc, busy, done, err;

  mult_controller #(.MULTIPLIER_WIDTH(3), .GUARD_WIDTH(3)) dut (
    .SYS_CLOCK   (clk),
    .SYS_RESET_N (rst_n),
    .START       (start),
    .B_GT_1      (b_gt_1),
    .COUNT_GT_2  (count_gt_2),
    .ALU_CONT    (alu_cont),
    .LOAD_A_REG  (la),
    .LOAD_B_REG  (lb),
    .LOAD_R1_REG (lr1),
    .LOAD_F_REG  (lf),
    .LOAD_COUNT  (lc),
    .DEC_COUNT   (dc),
    .BUSY        (busy),
    .DONE        (done),
    .ERROR       (err)
  );

  // Multiplier datapath driven by the controller.
  logic [3:0] a_in = '0;
  logic [2:0] b_in = '0;
  logic [3:0] a_reg = '0;
  logic [2:0] b_reg = '0;
  logic [7:0] r1 = '0, f_reg = '0, alu_out;
  logic [2:0] cnt = '0;

  always_comb begin
    case (alu_cont)
      2'b00:   alu_out = {4'b0, a_reg};
      2'b01:   alu_out = r1 + {4'b0, a_reg};
      default: alu_out = '0;
    endcase
  end

  always @(posedge clk) begin
    if (la)  a_reg <= a_in;
    if (lb)  b_reg <= b_in;
    if (lr1) r1    <= alu_out;
    if (lc)       cnt <= b_reg;
    else if (dc)  cnt <= cnt - 3'd1;
    if (lf)  f_reg <= (b_reg == 3'd0) ? 8'd0 : r1;
  end

  assign b_gt_1     = tie_status ? 1'b1 : ((cnt > 3'd2) || (b_reg > 3'd1));
  assign count_gt_2 = tie_status ? 1'b1 : (cnt > 3'd2);

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Idle/reset output pattern: all strobes 0, ALU_CONT = 10.
  task automatic chk_quiet(input string name, input int exp_err);
    chk({name, ".strobes"}, int'({la, lb, lr1, lf, lc, dc, busy, done}), 0);
    chk({name, ".alu"}, int'(alu_cont), 2);
    chk({name, ".error"}, int'(err), exp_err);
  endtask

  typedef struct {
    int adds, lat, dones, lfs, f, err_done, err_load;
  } res_t;

  // Issue one START pulse with operands a,b and observe 20 cycles after it.
  // Cycle k after the sampling edge is observed at the k-th following negedge.
  task automatic run_op(input logic [3:0] a, input logic [2:0] b,
                        input bit poke, output res_t r);
    bit poked = 0;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    r = '{adds: 0, lat: -1, dones: 0, lfs: 0, f: -1, err_done: -1, err_load: -1};
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) r.err_load = int'(err);
      if (dc) r.adds++;
      if (lf) r.lfs++;
      if (done) begin
        r.dones++;
        if (r.lat < 0) begin
          r.lat = k; r.f = int'(f_reg); r.err_done = int'(err);
        end
      end
      if (poke && dc && !poked) begin
        start = 1'b1; poked = 1;
      end
    end
  endtask

  // Reference: B-1 additions for B>=2, none otherwise; product A*B.
  task automatic chk_op(input string name, input int a, input int b, input res_t r);
    int exp_adds = (b < 2) ? 0 : b - 1;
    int exp_lat  = (b < 2) ? 5 : 4 + b;
    chk({name, ".adds"}, r.adds, exp_adds);
    chk({name, ".done_lat"}, r.lat, exp_lat);
    chk({name, ".done_cnt"}, r.dones, 1);
    chk({name, ".lf_cnt"}, r.lfs, 1);
    chk({name, ".product"}, r.f, a * b);
    chk({name, ".err_done"}, r.err_done, 0);
    chk({name, ".err_load"}, r.err_load, 0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [2:0] b;
    int exp_adds, exp_lat, exp_f;
  } vec_t;

  vec_t vecs[7];
  res_t r;

  initial begin
    vecs[0] = '{a: 4'd5,  b: 3'd3, exp_adds: 2, exp_lat: 7,  exp_f: 15};
    vecs[1] = '{a: 4'd7,  b: 3'd0, exp_adds: 0, exp_lat: 5,  exp_f: 0};
    vecs[2] = '{a: 4'd6,  b: 3'd1, exp_adds: 0, exp_lat: 5,  exp_f: 6};
    vecs[3] = '{a: 4'd7,  b: 3'd7, exp_adds: 6, exp_lat: 11, exp_f: 49};
    vecs[4] = '{a: 4'd3,  b: 3'd2, exp_adds: 1, exp_lat: 6,  exp_f: 6};
    vecs[5] = '{a: 4'd0,  b: 3'd5, exp_adds: 4, exp_lat: 9,  exp_f: 0};
    vecs[6] = '{a: 4'd15, b: 3'd7, exp_adds: 6, exp_lat: 11, exp_f: 105};

    rst_n = 1'b0; start = 1'b0; tie_status = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("idle_after_reset", 0);

    // Table-driven operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, r);
      chk($sformatf("vec%0d.adds", i), r.adds, vecs[i].exp_adds);
      chk($sformatf("vec%0d.done_lat", i), r.lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d.product", i), r.f, vecs[i].exp_f);
      chk($sformatf("vec%0d.done_cnt", i), r.dones, 1);
      chk($sformatf("vec%0d.err_done", i), r.err_done, 0);
    end

    // START pulsed during ADD of 5x3 is ignored.
    run_op(4'd5, 3'd3, 1'b1, r);
    chk_op("start_in_add", 5, 3, r);

    // Reset during the second ADD of a 7x7 operation.
    begin
      int seen = 0, dones = 0;
      @(negedge clk);
      a_in = 4'd7; b_in = 3'd7; start = 1'b1;
      for (int k = 1; k <= 20 && seen < 2; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (dc) seen++;
      end
      chk("rst_mid.reached_add2", seen, 2);
      rst_n = 1'b0;
      @(negedge clk);
      chk_quiet("rst_mid.after", 0);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (done || busy) dones++;
      end
      chk("rst_mid.no_done_busy", dones, 0);
    end
    run_op(4'd3, 3'd2, 1'b0, r);
    chk_op("after_rst", 3, 2, r);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 20; n++) begin
      logic [3:0] ra;
      logic [2:0] rb;
      ra = 4'($urandom_range(0, 15));
      rb = 3'($urandom_range(0, 7));
      run_op(ra, rb, 1'b0, r);
      chk_op($sformatf("rand%0d_%0dx%0d", n, ra, rb), int'(ra), int'(rb), r);
    end

    // Status stuck high: guard aborts after 6 additions.
    tie_status = 1'b1;
    run_op(4'd5, 3'd3, 1'b0, r);
    chk("guard.adds", r.adds, 6);
    chk("guard.done_lat", r.lat, 11);
    chk("guard.done_cnt", r.dones, 1);
    chk("guard.err_done", r.err_done, 1);
    chk("guard.lf_cnt", r.lfs, 0);
    tie_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("guard.idle_busy", int'(busy), 0);
    chk("guard.err_sticky", int'(err), 1);
    run_op(4'd4, 3'd3, 1'b0, r);
    chk_op("guard_clear", 4, 3, r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
